// File: rtl/uart_avalon_if.sv
// Avalon-MM register front end for a UART core: TX/RX byte FIFOs, status,
// interrupt control and the baud divisor register.
module uart_avalon_if #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] CLKDIV_RST = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [15:0] clk_div,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_CLKDIV = 2'd3;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] tx_count;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] rx_count;

  logic rx_ie, tx_ie, err_ie;
  logic tx_overflow, rx_overrun;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic bus_wr, bus_rd;
  logic wr_data, rd_data, wr_ctrl, wr_clkdiv;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_ovf_set, rx_ovr_set;
  logic [31:0] status_word, read_word;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == CW'(FIFO_DEPTH));

  // A simultaneous write wins; the read is dropped entirely.
  assign bus_wr    = write & ~reset;
  assign bus_rd    = read & ~write & ~reset;
  assign wr_data   = bus_wr & (address == A_DATA);
  assign wr_ctrl   = bus_wr & (address == A_CTRL);
  assign wr_clkdiv = bus_wr & (address == A_CLKDIV);
  assign rd_data   = bus_rd & (address == A_DATA);

  assign tx_pop     = tx_valid & tx_ready & ~reset;
  assign tx_push    = wr_data & (~tx_full | tx_pop);
  assign tx_ovf_set = wr_data & tx_full & ~tx_pop;

  assign rx_pop     = rd_data & ~rx_empty;
  assign rx_push    = rx_done & ~reset & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_done & ~reset & rx_full & ~rx_pop;

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;

  assign irq = (rx_ie & ~rx_empty) | (tx_ie & tx_empty) |
               (err_ie & (tx_overflow | rx_overrun));

  assign status_word = {8'h00, 8'(rx_count), 8'(tx_count), 2'b00,
                        rx_overrun, tx_overflow, rx_full, rx_empty,
                        tx_full, tx_empty};

  always_comb begin
    read_word = 32'h0;
    case (address)
      A_DATA:   read_word = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_mem[rx_rd_ptr]};
      A_STATUS: read_word = status_word;
      A_CTRL:   read_word = {29'b0, err_ie, tx_ie, rx_ie};
      A_CLKDIV: read_word = {16'h0, clk_div};
      default:  read_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= writedata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Sticky error flags: a set event in the same cycle beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ie       <= 1'b0;
      tx_ie       <= 1'b0;
      err_ie      <= 1'b0;
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
      clk_div     <= CLKDIV_RST;
      readdata    <= 32'h0;
    end else begin
      if (wr_ctrl) begin
        rx_ie  <= writedata[0];
        tx_ie  <= writedata[1];
        err_ie <= writedata[2];
      end
      tx_overflow <= (tx_overflow & ~(wr_ctrl & writedata[4])) | tx_ovf_set;
      rx_overrun  <= (rx_overrun  & ~(wr_ctrl & writedata[5])) | rx_ovr_set;
      if (wr_clkdiv) clk_div <= writedata[15:0];
      if (bus_rd)    readdata <= read_word;
    end
  end

endmodule
